// File: rtl/controlador_registro4bits_pkg.sv
// Shared definitions for the 4-bit universal shift register and its sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package registro4bits_defs;

    // Register mode pins: modo[1] set means parallel load regardless of modo[0].
    localparam logic [1:0] MODO_SERIE = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_CARGA = 2'b10;

    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;

    typedef enum logic [1:0] {
        OP_TX   = 2'b00,
        OP_RX   = 2'b01,
        OP_ROT  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ROT   = 3'd3,
        ST_RESP  = 3'd4
    } estado_t;

endpackage

// File: rtl/controlador_registro4bits_contador_pasos.sv
// Loadable down-counter with zero flag; sets the length of SHIFT/ROT phases.
// Latency: load/decrement take effect at the next clock edge.
// Backpressure: none; the counter only moves when told to.
module contador_pasos #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carga,
    input  logic [CNT_W-1:0] valor,
    input  logic             decr,
    output logic [CNT_W-1:0] cuenta,
    output logic             cero
);

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (decr && (cuenta != '0)) begin
            cuenta <= cuenta - CNT_W'(1);
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/controlador_registro4bits.sv
// Command sequencer driving a 4-bit universal shift register for TX/RX/ROT/LOAD.
// Latency accept->rsp_valid: TX 6, RX 5, LOAD 2, ROT 2+count cycles.
// Backpressure: response held in RESP until rsp_ready; no command accepted meanwhile.
module controlador_registro4bits
    import registro4bits_defs::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             reg_enb,
    output logic [1:0]       reg_modo,
    output logic             reg_dir,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_s_in,
    input  logic [WIDTH-1:0] reg_q,
    input  logic             reg_s_out
);

    estado_t          estado, estado_sig;
    op_t              op_q;
    logic             dir_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             resp_primero;
    logic             acepta;
    logic             cnt_carga;
    logic [CNT_W-1:0] cnt_valor;
    logic             cnt_decr;
    logic [CNT_W-1:0] cnt_cuenta;
    logic             cnt_cero;

    contador_pasos #(.CNT_W(CNT_W)) u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .carga  (cnt_carga),
        .valor  (cnt_valor),
        .decr   (cnt_decr),
        .cuenta (cnt_cuenta),
        .cero   (cnt_cero)
    );

    // State register plus command fields latched on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado  <= ST_IDLE;
            op_q    <= OP_TX;
            dir_q   <= 1'b0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            estado <= estado_sig;
            if (acepta) begin
                op_q    <= op_t'(cmd_op);
                dir_q   <= cmd_dir;
                count_q <= cmd_count;
                data_q  <= cmd_data;
            end
        end
    end

    // The register holds (enb=0) throughout RESP, so reg_q in the first RESP
    // cycle is the final result; it is captured then and replayed afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_primero <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            resp_primero <= (estado_sig == ST_RESP) && (estado != ST_RESP);
            if ((estado == ST_RESP) && resp_primero) begin
                rsp_data_q <= reg_q;
            end
        end
    end

    assign rsp_data = ((estado == ST_RESP) && resp_primero) ? reg_q : rsp_data_q;
    assign ser_out  = reg_s_out;
    assign busy     = (estado != ST_IDLE);

    // Next-state logic and Moore decode of the register-facing pins.
    always_comb begin
        estado_sig = estado;
        cmd_ready  = 1'b0;
        acepta     = 1'b0;
        rsp_valid  = 1'b0;
        ser_valid  = 1'b0;
        reg_enb    = 1'b0;
        reg_modo   = MODO_SERIE;
        reg_dir    = 1'b0;
        reg_d      = '0;
        reg_s_in   = 1'b0;
        cnt_carga  = 1'b0;
        cnt_valor  = '0;
        cnt_decr   = 1'b0;
        case (estado)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    acepta = 1'b1;
                    if (op_t'(cmd_op) == OP_RX) begin
                        estado_sig = ST_SHIFT;
                        cnt_carga  = 1'b1;
                        cnt_valor  = CNT_W'(WIDTH - 1);
                    end else begin
                        estado_sig = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                reg_enb  = 1'b1;
                reg_modo = MODO_CARGA;
                reg_d    = data_q;
                case (op_q)
                    OP_TX: begin
                        estado_sig = ST_SHIFT;
                        cnt_carga  = 1'b1;
                        cnt_valor  = CNT_W'(WIDTH - 1);
                    end
                    OP_ROT: begin
                        if (count_q != '0) begin
                            estado_sig = ST_ROT;
                            cnt_carga  = 1'b1;
                            cnt_valor  = count_q - CNT_W'(1);
                        end else begin
                            estado_sig = ST_RESP;
                        end
                    end
                    default: estado_sig = ST_RESP;
                endcase
            end
            ST_SHIFT: begin
                reg_enb   = 1'b1;
                reg_modo  = MODO_SERIE;
                reg_dir   = dir_q;
                ser_valid = 1'b1;
                reg_s_in  = (op_q == OP_RX) ? ser_in : 1'b0;
                if (cnt_cero) begin
                    estado_sig = ST_RESP;
                end else begin
                    cnt_decr = 1'b1;
                end
            end
            ST_ROT: begin
                reg_enb  = 1'b1;
                reg_modo = MODO_ROT;
                reg_dir  = dir_q;
                if (cnt_cero) begin
                    estado_sig = ST_RESP;
                end else begin
                    cnt_decr = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    estado_sig = ST_IDLE;
                end
            end
            default: estado_sig = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_controlador_registro4bits.sv
// Self-checking bench: directed plus random commands against a behavioural model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low for a chosen number of cycles.
module tb_controlador_registro4bits;

    localparam logic [1:0] T_TX = 2'b00, T_RX = 2'b01, T_ROT = 2'b10, T_LOAD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [1:0] cmd_count;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       ser_in;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
    logic       reg_enb;
    logic [1:0] reg_modo;
    logic       reg_dir;
    logic [3:0] reg_d;
    logic       reg_s_in;
    logic [3:0] reg_q;
    logic       reg_s_out;

    logic [3:0] q = 4'b0000;
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    controlador_registro4bits #(.WIDTH(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .reg_enb   (reg_enb),
        .reg_modo  (reg_modo),
        .reg_dir   (reg_dir),
        .reg_d     (reg_d),
        .reg_s_in  (reg_s_in),
        .reg_q     (reg_q),
        .reg_s_out (reg_s_out)
    );

    // External 4-bit universal shift register the controller drives.
    always @(posedge clk) begin
        if (reg_enb) begin
            if (reg_modo[1])          q <= reg_d;
            else if (reg_modo[0])     q <= reg_dir ? {q[0], q[3:1]} : {q[2:0], q[3]};
            else                      q <= reg_dir ? {reg_s_in, q[3:1]} : {q[2:0], reg_s_in};
        end
    end
    assign reg_q     = q;
    assign reg_s_out = reg_dir ? q[0] : q[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result computed from the command semantics with plain arithmetic.
    function automatic int ref_rsp(input logic [1:0] op, input logic dir, input int c,
                                   input int d, input logic [3:0] bits);
        int v;
        case (op)
            T_LOAD: return d;
            T_TX:   return 0;
            T_ROT:  begin
                if (dir) return ((d >> c) | (d << (4 - c))) % 16;
                else     return ((d << c) | (d >> (4 - c))) % 16;
            end
            default: begin
                v = 0;
                for (int i = 0; i < 4; i++) begin
                    if (dir) v = v / 2 + (bits[i] ? 8 : 0);
                    else     v = (v * 2 + (bits[i] ? 1 : 0)) % 16;
                end
                return v;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input int c);
        case (op)
            T_TX:    return 6;
            T_RX:    return 5;
            T_LOAD:  return 2;
            default: return 2 + c;
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [1:0] cnt,
                           input logic [3:0] data, input logic [3:0] bits, input int bp);
        int         edges;
        int         nser;
        bit         seen;
        logic [3:0] sout;
        logic [3:0] exp_sout;
        logic [3:0] hold;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_count = cnt; cmd_data = data;
        @(posedge clk); #1;
        // Scramble the command bus while busy; it must be ignored.
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_dir = 1'($urandom);
        cmd_count = 2'($urandom); cmd_data = 4'($urandom);
        edges = 0; nser = 0; seen = 0; sout = 4'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            if (ser_valid) begin
                if (nser < 4) begin
                    sout[nser] = ser_out;
                    ser_in     = bits[nser];
                end
                nser++;
            end else begin
                ser_in = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        ser_in = 1'b0;
        if (!seen) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", edges + 1, ref_lat(op, int'(cnt)));
        check("rsp_data", rsp_data, ref_rsp(op, dir, int'(cnt), int'(data), bits));
        check("ser_valid_cycles", nser, (op == T_TX || op == T_RX) ? 4 : 0);
        if (op == T_TX) begin
            for (int i = 0; i < 4; i++) exp_sout[i] = dir ? data[i] : data[3 - i];
            check("tx_ser_out", sout, exp_sout);
        end
        if (op == T_LOAD) check("reg_q_load", reg_q, data);
        hold = rsp_data;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, hold);
            check("bp_enb_rdy", {reg_enb, cmd_ready, busy}, 3'b001);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {busy, rsp_valid, ser_valid, reg_enb, reg_modo, reg_dir, reg_d,
                    reg_s_in, cmd_ready, rsp_data}, 18'h0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
        cmd_count = 2'b00; cmd_data = 4'h0; rsp_ready = 1'b0; ser_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", cmd_ready, 1);

        run_cmd(T_LOAD, 1'b0, 2'd0, 4'b1010, 4'b0000, 0);
        run_cmd(T_TX,   1'b0, 2'd0, 4'b1010, 4'b0000, 0);
        run_cmd(T_RX,   1'b0, 2'd0, 4'b0000, 4'b1011, 1);  // ser_in 1,1,0,1 -> 1101
        run_cmd(T_ROT,  1'b0, 2'd1, 4'b0111, 4'b0000, 0);
        run_cmd(T_ROT,  1'b1, 2'd2, 4'b0111, 4'b0000, 0);
        run_cmd(T_ROT,  1'b0, 2'd0, 4'b0111, 4'b0000, 0);
        run_cmd(T_ROT,  1'b1, 2'd3, 4'b0110, 4'b0000, 5);
        run_cmd(T_TX,   1'b1, 2'd0, 4'b1101, 4'b0000, 0);

        // Abort a TX during its second shift cycle.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = T_TX; cmd_dir = 1'b0; cmd_data = 4'b1011;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_tx_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort_reset_values");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {rsp_valid, busy}, 2'b00);
        end
        run_cmd(T_LOAD, 1'b0, 2'd0, 4'b0001, 4'b0000, 0);

        for (int n = 0; n < 24; n++) begin
            run_cmd(2'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                    4'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
